// File: rtl/uart_cmd_receiver_if.sv
// Serial-line and received-command signals between the UART receiver and the command decoder.
interface uart_cmd_receiver_if;
  logic       UART_RXD;
  logic [7:0] RXD_DATA;
  logic       RXD_OVER;
  logic       FRAME_ERR;
  logic       BUSY;

  modport master (
    input  UART_RXD,
    output RXD_DATA,
    output RXD_OVER,
    output FRAME_ERR,
    output BUSY
  );

  modport slave (
    output UART_RXD,
    input  RXD_DATA,
    input  RXD_OVER,
    input  FRAME_ERR,
    input  BUSY
  );
endinterface

// File: rtl/uart_cmd_receiver.sv
// 8N1 UART receiver for the Bluetooth command path: baud tick divider plus
// 16x oversampling frame FSM, delivering a held byte and a one-cycle strobe.
module uart_cmd_receiver #(
  parameter int unsigned CLK_DIV    = 650,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                CLK,
  input  logic                RST,
  uart_cmd_receiver_if.master rx
);

  localparam int unsigned HALF   = OVERSAMPLE / 2;
  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TCNT_W = $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t              state, state_nx;
  logic                rx_meta, rx_s;
  logic [DIV_W-1:0]    div;
  logic [TCNT_W-1:0]   tcnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shift;

  logic tick, mid_start, bit_end;
  logic cnt_clr, tcnt_clr, shift_en, stop_ok, stop_bad, busy;

  assign tick      = (div == DIV_W'(CLK_DIV - 1));
  assign mid_start = tick && (tcnt == TCNT_W'(HALF - 1));
  assign bit_end   = tick && (tcnt == TCNT_W'(OVERSAMPLE - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx.UART_RXD;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (!rx_s) state_nx = START;
      START:     if (mid_start) state_nx = rx_s ? IDLE : DATA;
      DATA:      if (bit_end && (bit_idx == 3'd7)) state_nx = STOP;
      STOP:      if (bit_end) state_nx = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    // counters sit at zero while idle so the first tick is phase-aligned to the start edge
    cnt_clr  = (state == IDLE) || (state == WAIT_HIGH);
    tcnt_clr = ((state == START) && mid_start) || bit_end;
    shift_en = (state == DATA) && bit_end;
    stop_ok  = (state == STOP) && bit_end && rx_s;
    stop_bad = (state == STOP) && bit_end && !rx_s;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div     <= '0;
      tcnt    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else if (cnt_clr) begin
      div     <= '0;
      tcnt    <= '0;
      bit_idx <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) tcnt <= tcnt_clr ? '0 : tcnt + 1'b1;
      if (shift_en) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx.RXD_DATA  <= '0;
      rx.RXD_OVER  <= 1'b0;
      rx.FRAME_ERR <= 1'b0;
    end else begin
      rx.RXD_OVER  <= stop_ok;
      rx.FRAME_ERR <= stop_bad;
      if (stop_ok) rx.RXD_DATA <= shift;
    end
  end

  assign rx.BUSY = busy;

endmodule

// File: tb/tb_uart_cmd_receiver.sv
// Directed bench for uart_cmd_receiver: table of frames plus hand-written corner sequences.
module tb_uart_cmd_receiver;

  localparam int unsigned DIV  = 5;
  localparam int unsigned OS   = 16;
  localparam int unsigned BCLK = DIV * OS;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_cmd_receiver_if bus ();

  uart_cmd_receiver #(.CLK_DIV(DIV), .OVERSAMPLE(OS)) dut (
    .CLK (clk),
    .RST (rst_n),
    .rx  (bus.master)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned over_cnt = 0;
  int unsigned ferr_cnt = 0;
  logic [7:0]  rx_q[$];
  logic        prev_over = 1'b0;
  logic        prev_ferr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.RXD_OVER) begin
        over_cnt++;
        rx_q.push_back(bus.RXD_DATA);
      end
      if (bus.FRAME_ERR) ferr_cnt++;
      if (bus.RXD_OVER || bus.FRAME_ERR)
        check("pulse_shape",
              {29'd0, bus.RXD_OVER & bus.FRAME_ERR, bus.RXD_OVER & prev_over, bus.FRAME_ERR & prev_ferr},
              32'd0);
      prev_over = bus.RXD_OVER;
      prev_ferr = bus.FRAME_ERR;
    end else begin
      prev_over = 1'b0;
      prev_ferr = 1'b0;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input int unsigned bclk);
    bus.UART_RXD = 1'b0;
    repeat (bclk) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.UART_RXD = b[i];
      repeat (bclk) @(posedge clk);
    end
    bus.UART_RXD = stop;
    repeat (bclk) @(posedge clk);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40 * BCLK; n++) begin
      @(negedge clk);
      if (!bus.BUSY) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    int unsigned bclk;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned o0, f0;
    bit          ok;
    logic [7:0]  v;
    logic [7:0]  got;

    vecs[0] = '{data: 8'h02, bclk: BCLK,     exp_data: 8'h02};
    vecs[1] = '{data: 8'h55, bclk: BCLK - 2, exp_data: 8'h55};
    vecs[2] = '{data: 8'hFF, bclk: BCLK + 2, exp_data: 8'hFF};
    vecs[3] = '{data: 8'h00, bclk: BCLK,     exp_data: 8'h00};
    vecs[4] = '{data: 8'h80, bclk: BCLK,     exp_data: 8'h80};

    rst_n = 1'b0;
    bus.UART_RXD = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_data",  bus.RXD_DATA, 8'h00);
    check("rst_over",  bus.RXD_OVER, 1'b0);
    check("rst_ferr",  bus.FRAME_ERR, 1'b0);
    check("rst_busy",  bus.BUSY, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (BCLK) @(posedge clk);

    for (int i = 0; i < 5; i++) begin
      o0 = over_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[i].data, 1'b1, vecs[i].bclk);
      bus.UART_RXD = 1'b1;
      repeat (BCLK) @(posedge clk);
      wait_idle(ok);
      check($sformatf("vec%0d_idle", i), {31'd0, ok}, 32'd1);
      check($sformatf("vec%0d_over", i), over_cnt - o0, 32'd1);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, 32'd0);
      check($sformatf("vec%0d_data", i), bus.RXD_DATA, vecs[i].exp_data);
    end

    // back-to-back frames with no idle gap
    rx_q.delete();
    send_frame(8'h01, 1'b1, BCLK);
    send_frame(8'h0B, 1'b1, BCLK);
    send_frame(8'hA5, 1'b1, BCLK);
    bus.UART_RXD = 1'b1;
    repeat (BCLK) @(posedge clk);
    wait_idle(ok);
    check("b2b_idle", {31'd0, ok}, 32'd1);
    check("b2b_count", rx_q.size(), 32'd3);
    for (int k = 0; k < 3; k++) begin
      got = (k < rx_q.size()) ? rx_q[k] : 8'hxx;
      v = (k == 0) ? 8'h01 : (k == 1) ? 8'h0B : 8'hA5;
      check($sformatf("b2b_byte%0d", k), got, v);
    end
    check("b2b_held", bus.RXD_DATA, 8'hA5);

    // stop bit low, line held low for 3 more bit times
    o0 = over_cnt;
    f0 = ferr_cnt;
    send_frame(8'h03, 1'b0, BCLK);
    repeat (3 * BCLK) @(posedge clk);
    @(negedge clk);
    check("ferr_pulse", ferr_cnt - f0, 32'd1);
    check("ferr_no_over", over_cnt - o0, 32'd0);
    check("ferr_busy_low_line", bus.BUSY, 1'b1);
    check("ferr_data_kept", bus.RXD_DATA, 8'hA5);
    bus.UART_RXD = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("ferr_busy_released", bus.BUSY, 1'b0);

    // 3-tick glitch on an idle line
    repeat (BCLK) @(posedge clk);
    o0 = over_cnt;
    f0 = ferr_cnt;
    bus.UART_RXD = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("glitch_start_seen", bus.BUSY, 1'b1);
    repeat (5) @(posedge clk);
    bus.UART_RXD = 1'b1;
    repeat (2 * BCLK) @(posedge clk);
    @(negedge clk);
    check("glitch_idle", bus.BUSY, 1'b0);
    check("glitch_no_over", over_cnt - o0, 32'd0);
    check("glitch_no_ferr", ferr_cnt - f0, 32'd0);
    check("glitch_data_kept", bus.RXD_DATA, 8'hA5);

    // reset asserted in the middle of bit 4 of 8'h04
    o0 = over_cnt;
    f0 = ferr_cnt;
    v = 8'h04;
    bus.UART_RXD = 1'b0;
    repeat (BCLK) @(posedge clk);
    for (int b = 0; b < 4; b++) begin
      bus.UART_RXD = v[b];
      repeat (BCLK) @(posedge clk);
    end
    bus.UART_RXD = v[4];
    repeat (BCLK / 2) @(posedge clk);
    #1;
    check("midrst_busy_before", bus.BUSY, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_data", bus.RXD_DATA, 8'h00);
    check("midrst_busy", bus.BUSY, 1'b0);
    check("midrst_over", bus.RXD_OVER, 1'b0);
    check("midrst_ferr", bus.FRAME_ERR, 1'b0);
    bus.UART_RXD = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (BCLK) @(posedge clk);
    check("midrst_no_over", over_cnt - o0, 32'd0);
    check("midrst_no_ferr", ferr_cnt - f0, 32'd0);
    send_frame(8'h05, 1'b1, BCLK);
    bus.UART_RXD = 1'b1;
    repeat (BCLK) @(posedge clk);
    wait_idle(ok);
    check("post_rst_idle", {31'd0, ok}, 32'd1);
    check("post_rst_over", over_cnt - o0, 32'd1);
    check("post_rst_data", bus.RXD_DATA, 8'h05);

    repeat (10) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
